// File: rtl/mips_lsu.sv
// mips_lsu: multi-cycle load/store unit between execute and data memory.
//
// Ports
//   clk, rst_b          clock (rising edge), asynchronous active-low reset
//   req_*               access from execute (valid/ready), byte address,
//                       size in bytes (1/2/4), signedness, store data, dest reg
//   mem_req_* / mem_*   word-addressed data-memory request port with lane strobes
//   mem_resp_valid/rdata load response (loads only)
//   wb_valid/rd/data    one-cycle load writeback; rd/data hold between pulses
//   st_done             one-cycle pulse when a store is accepted by memory
//   exc_addr_err        one-cycle pulse for misaligned access or illegal size
//   exc_bus_err         one-cycle pulse when ISSUE+WAIT exceeds TIMEOUT cycles
//   dbg_state           current FSM state (0 idle, 1 issue, 2 wait)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once mem_req_valid is raised it stays high, with address/data/
// strobes unchanged, until mem_req_ready is seen or the access times out.
module mips_lsu #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        st_done,
  output logic        exc_addr_err,
  output logic        exc_bus_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             store_q, store_d;
  logic [2:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [4:0]       rd_q, rd_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             st_done_q, st_done_d;
  logic             exc_addr_q, exc_addr_d;
  logic             exc_bus_q, exc_bus_d;

  logic [1:0]       req_off;
  logic             legal;
  logic [CNT_W:0]   cnt_inc;
  logic             timeout_hit;
  logic [31:0]      lane_word;
  logic [31:0]      load_ext;

  // Request decode and load-lane extraction.
  always_comb begin
    req_off     = req_addr[1:0];
    legal       = (req_size == 3'd1) ||
                  (req_size == 3'd2 && !req_addr[0]) ||
                  (req_size == 3'd4 && req_off == 2'b00);
    // One extra bit so the compare cannot wrap after a last-cycle handshake.
    cnt_inc     = {1'b0, cnt_q} + (CNT_W+1)'(1);
    timeout_hit = cnt_inc >= (CNT_W+1)'(TIMEOUT);
    lane_word   = mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      3'd1:    load_ext = uns_q ? {24'h0, lane_word[7:0]}
                                : {{24{lane_word[7]}}, lane_word[7:0]};
      3'd2:    load_ext = uns_q ? {16'h0, lane_word[15:0]}
                                : {{16{lane_word[15]}}, lane_word[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    store_d    = store_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    st_done_d  = 1'b0;
    exc_addr_d = 1'b0;
    exc_bus_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          store_d = req_store;
          size_d  = req_size;
          uns_d   = req_unsigned;
          rd_d    = req_rd;
          wstrb_d = 4'b0000;
          wdata_d = 32'h0;
          if (req_store) begin
            case (req_size)
              3'd1: begin
                wstrb_d = 4'b0001 << req_off;
                wdata_d = {4{req_wdata[7:0]}};
              end
              3'd2: begin
                wstrb_d = 4'b0011 << req_off;
                wdata_d = {2{req_wdata[15:0]}};
              end
              3'd4: begin
                wstrb_d = 4'b1111;
                wdata_d = req_wdata;
              end
              default: begin
                wstrb_d = 4'b0000;
                wdata_d = 32'h0;
              end
            endcase
          end
          if (legal) begin
            state_d = S_ISSUE;
            cnt_d   = '0;
          end else begin
            exc_addr_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_inc[CNT_W-1:0];
        // A handshake in the timeout cycle takes priority over the error.
        if (mem_req_ready) begin
          if (store_q) begin
            st_done_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timeout_hit) begin
          exc_bus_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc[CNT_W-1:0];
        if (mem_resp_valid) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = load_ext;
          state_d    = S_IDLE;
        end else if (timeout_hit) begin
          exc_bus_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= 32'h0;
      store_q    <= 1'b0;
      size_q     <= 3'd0;
      uns_q      <= 1'b0;
      rd_q       <= 5'd0;
      wstrb_q    <= 4'b0000;
      wdata_q    <= 32'h0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'h0;
      st_done_q  <= 1'b0;
      exc_addr_q <= 1'b0;
      exc_bus_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      st_done_q  <= st_done_d;
      exc_addr_q <= exc_addr_d;
      exc_bus_q  <= exc_bus_d;
    end
  end

  // Memory-side fields read as zero whenever no request is being presented.
  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_ISSUE);
  assign mem_addr      = mem_req_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_we        = mem_req_valid & store_q;
  assign mem_wstrb     = mem_req_valid ? wstrb_q : 4'b0000;
  assign mem_wdata     = mem_req_valid ? wdata_q : 32'h0;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign st_done       = st_done_q;
  assign exc_addr_err  = exc_addr_q;
  assign exc_bus_err   = exc_bus_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
- Multi-cycle load/store unit that consumes the memory-control fields produced by instruction decode: access size, signedness, and store enable.
- Drives a valid/ready word-addressed data-memory port and returns sign- or zero-extended load results for register writeback.
- Sits between the execute stage (address already computed by the ALU) and data memory.
- Reports misaligned accesses and memory timeouts as one-cycle exception pulses.

Parameters:
- TIMEOUT, 64, max cycles spent in ISSUE+WAIT before aborting with exc_bus_err; must be ≥ 2.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- req_valid  in  1  execute stage presents an access.
- req_ready  out  1  LSU idle and able to accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  3  access bytes: 1, 2 or 4; any other value is illegal.
- req_unsigned  in  1  load zero-extends (LBU/LHU); ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  load destination register.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_we  out  1  store request.
- mem_wstrb  out  4  byte-lane enables; bit i = byte lane i (little-endian).
- mem_wdata  out  32  store data placed in the correct lanes.
- mem_resp_valid  in  1  load data valid (loads only).
- mem_rdata  in  32  load word.
- wb_valid  out  1  one-cycle load writeback pulse.
- wb_rd  out  5  writeback register.
- wb_data  out  32  extended load value.
- st_done  out  1  one-cycle pulse: store accepted by memory.
- exc_addr_err  out  1  one-cycle pulse: misaligned access or illegal size.
- exc_bus_err  out  1  one-cycle pulse: timeout.

Behaviour:
- Reset: async assertion forces state IDLE, timeout counter 0, and all outputs 0 except req_ready = 1. Applies mid-operation; an in-flight request is discarded and any later mem_resp_valid is ignored.
- States:
  - IDLE: req_ready = 1.
  - ISSUE: mem_req_valid = 1.
  - WAIT: load awaiting response.
  - req_ready = 0 outside IDLE.
- IDLE transitions: on req_valid, latch all req_* fields, then check alignment:
  - Illegal if size ∉ {1,2,4}, or size 2 with addr[0] = 1, or size 4 with addr[1:0] ≠ 0.
  - Illegal: exc_addr_err pulses on the next cycle, no memory access, state stays IDLE.
  - Legal: go to ISSUE.
- Lane formatting (off = addr[1:0]):
  - Size 1: mem_wstrb = 0001 << off; mem_wdata = {4{wdata[7:0]}}.
  - Size 2: mem_wstrb = 0011 << off; mem_wdata = {2{wdata[15:0]}}.
  - Size 4: mem_wstrb = 1111; mem_wdata = wdata.
  - Loads: mem_wstrb = 0000, mem_we = 0.
- ISSUE: mem_addr, mem_we, mem_wstrb and mem_wdata are held stable while mem_req_valid = 1 and mem_req_ready = 0.
  - On the handshake, a store drives st_done = 1 on the next cycle and returns to IDLE.
  - On the handshake, a load goes to WAIT.
- WAIT: the first mem_resp_valid captures the lane:
  - Byte: b = rdata[8*off +: 8]. Half: h = rdata[8*off +: 16].
  - Extend to 32 bits: zero-extend if req_unsigned, else sign-extend.
  - The next cycle drives wb_valid = 1 with wb_rd and wb_data, then returns to IDLE.
- Outputs between pulses: wb_data and wb_rd hold their last value when wb_valid = 0.
- Latency: best-case load is accept (cycle 0) → ISSUE handshake (cycle 1) → response (cycle 2) → wb_valid (cycle 3). Best-case store: st_done at cycle 2.
- Timeout counter:
  - Clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - Reaching TIMEOUT without completion pulses exc_bus_err, drops mem_req_valid, and returns to IDLE.
  - A handshake or response arriving in the same cycle the counter reaches TIMEOUT wins; there is no error in that case.
- mem_resp_valid outside WAIT is ignored.
- No pulse output is asserted for more than one cycle, and no two pulse outputs are asserted in the same cycle.

Test Plan:
- Store SB, addr 0x1003, wdata 0xAB, mem_req_ready = 1 → mem_addr 0x1000, wstrb 1000, wdata 0xABABABAB, st_done at cycle 2.
- Load LB, addr 0x2001, rdata 0x1234_80FF → wb_data 0xFFFFFF80, wb_rd echoed, wb_valid at cycle 3. Same access as LBU → wb_data 0x00000080.
- LH at 0x2002 with rdata 0x8001_0000 → 0xFFFF8001. LW at 0x2006 → exc_addr_err pulse, no mem_req_valid. req_size 3 → exc_addr_err.
- mem_req_ready held low 5 cycles on a SW → all mem_* outputs stable for 6 cycles, then a single st_done.
- Load with TIMEOUT = 8 and no response → exc_bus_err exactly once at cycle 9, req_ready = 1 afterward, and a late mem_resp_valid produces no wb_valid.
- rst_b asserted low during WAIT → immediate IDLE with all outputs 0; a response after reset release is ignored.
